// File: rtl/sme_stream_adapter_if.sv
// Stream bundle around the adapter: AXI-Stream in, SOP/EOP/empty out.
// The slave modport is the adapter's view; master is the environment's.
interface sme_stream_adapter_if #(
    parameter int BYTE_COUNT = 16
) ();
    localparam int EMPTY_W = $clog2(BYTE_COUNT);

    logic [BYTE_COUNT*8-1:0] s_axis_tdata;
    logic [BYTE_COUNT-1:0]   s_axis_tkeep;
    logic                    s_axis_tvalid;
    logic                    s_axis_tlast;
    logic                    s_axis_tready;

    logic [BYTE_COUNT*8-1:0] out_data;
    logic [EMPTY_W-1:0]      out_empty;
    logic                    out_valid;
    logic                    out_sop;
    logic                    out_eop;
    logic                    out_ready;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output out_data, out_empty, out_valid, out_sop, out_eop,
        input  out_ready
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  out_data, out_empty, out_valid, out_sop, out_eop,
        output out_ready
    );
endinterface

// File: rtl/sme_stream_adapter.sv
// AXI-Stream to SOP/EOP/empty byte-reversed stream through a 2-entry skid,
// plus per-packet tail bytes and byte length capture.
module sme_stream_adapter #(
    parameter int         BYTE_COUNT = 16,
    parameter int         TAIL_BYTES = 7,
    parameter logic [7:0] PAD_BYTE   = 8'hFF,
    parameter int         LEN_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    sme_stream_adapter_if.slave              s,
    output logic [TAIL_BYTES*8-1:0]          tail_data,
    output logic [$clog2(TAIL_BYTES+1)-1:0]  tail_len,
    output logic [LEN_W-1:0]                 pkt_len,
    output logic                             tail_valid,
    output logic                             keep_err
);
    localparam int EMPTY_W = $clog2(BYTE_COUNT);
    localparam int CNT_W   = $clog2(BYTE_COUNT + 1);
    localparam int TL_W    = $clog2(TAIL_BYTES + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef struct packed {
        logic [BYTE_COUNT*8-1:0] data;
        logic [EMPTY_W-1:0]      empty;
        logic                    sop;
        logic                    eop;
    } beat_t;

    beat_t main_q, main_d, skid_q, skid_d, in_beat;
    logic  main_valid_q, main_valid_d;
    logic  skid_full_q, skid_full_d;
    logic  tready_q, tready_d;
    logic  in_pkt_q, in_pkt_d;

    logic [TAIL_BYTES*8-1:0] tail_acc_q, tail_acc_d;
    logic [TAIL_BYTES*8-1:0] tail_data_q, tail_data_d;
    logic [LEN_W-1:0]        len_acc_q, len_acc_d;
    logic [LEN_W-1:0]        pkt_len_q, pkt_len_d;
    logic [TL_W-1:0]         tail_len_q, tail_len_d;
    logic                    tail_valid_q, tail_valid_d;
    logic                    keep_err_q, keep_err_d;

    logic                    accept;
    logic [CNT_W-1:0]        n_bytes;
    logic [BYTE_COUNT-1:0]   keep_plus1;
    logic                    malformed;
    logic [TAIL_BYTES*8-1:0] tail_base;
    logic [TAIL_BYTES*8-1:0] tail_merged;
    logic [LEN_W-1:0]        len_base;
    logic [LEN_W:0]          len_sum;
    logic [LEN_W-1:0]        len_next;

    assign accept = s.s_axis_tvalid && tready_q;

    always_comb begin : beat_decode
        n_bytes = '0;
        for (int k = 0; k < BYTE_COUNT; k++) begin
            n_bytes = n_bytes + CNT_W'(s.s_axis_tkeep[k]);
        end
        in_beat = '0;
        for (int k = 0; k < BYTE_COUNT; k++) begin
            in_beat.data[(BYTE_COUNT-1-k)*8 +: 8] =
                s.s_axis_tkeep[k] ? s.s_axis_tdata[k*8 +: 8] : PAD_BYTE;
        end
        in_beat.sop = !in_pkt_q;
        in_beat.eop = s.s_axis_tlast;
        // A zero-keep eop would wrap to 0 empty; report the largest encodable instead.
        if (!s.s_axis_tlast) begin
            in_beat.empty = '0;
        end else if (s.s_axis_tkeep == '0) begin
            in_beat.empty = EMPTY_W'(BYTE_COUNT - 1);
        end else begin
            in_beat.empty = EMPTY_W'(BYTE_COUNT - int'(n_bytes));
        end
        keep_plus1 = s.s_axis_tkeep + BYTE_COUNT'(1);
        malformed  = ((s.s_axis_tkeep & keep_plus1) != '0) ||
                     (s.s_axis_tkeep == '0) ||
                     (!s.s_axis_tlast && (s.s_axis_tkeep != '1));
    end

    always_comb begin : tail_merge
        tail_base   = in_pkt_q ? tail_acc_q : {TAIL_BYTES{PAD_BYTE}};
        tail_merged = tail_base;
        // Byte i of the tail is the i-th byte from the end of the packet so far.
        for (int i = 0; i < TAIL_BYTES; i++) begin
            if (i < int'(n_bytes)) begin
                tail_merged[i*8 +: 8] = s.s_axis_tdata[(int'(n_bytes)-1-i)*8 +: 8];
            end else begin
                tail_merged[i*8 +: 8] = tail_base[(i-int'(n_bytes))*8 +: 8];
            end
        end
        len_base = in_pkt_q ? len_acc_q : '0;
        len_sum  = {1'b0, len_base} + (LEN_W+1)'(n_bytes);
        len_next = len_sum[LEN_W] ? LEN_MAX : len_sum[LEN_W-1:0];
    end

    always_comb begin : next_state
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_full_d  = skid_full_q;
        in_pkt_d     = in_pkt_q;
        tail_acc_d   = tail_acc_q;
        len_acc_d    = len_acc_q;
        tail_data_d  = tail_data_q;
        tail_len_d   = tail_len_q;
        pkt_len_d    = pkt_len_q;
        tail_valid_d = accept && s.s_axis_tlast;
        keep_err_d   = accept && malformed;

        if (accept) begin
            in_pkt_d   = !s.s_axis_tlast;
            tail_acc_d = tail_merged;
            len_acc_d  = len_next;
            if (s.s_axis_tlast) begin
                tail_data_d = tail_merged;
                pkt_len_d   = len_next;
                tail_len_d  = (len_next >= LEN_W'(TAIL_BYTES)) ? TL_W'(TAIL_BYTES)
                                                               : len_next[TL_W-1:0];
            end
        end

        // Skid only fills while main is stalled; ready is withheld while it is full.
        if (!main_valid_q || s.out_ready) begin
            if (skid_full_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_full_d  = 1'b0;
            end else if (accept) begin
                main_d       = in_beat;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d      = in_beat;
            skid_full_d = 1'b1;
        end
        tready_d = !skid_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_full_q  <= 1'b0;
            tready_q     <= 1'b0;
            in_pkt_q     <= 1'b0;
            tail_acc_q   <= {TAIL_BYTES{PAD_BYTE}};
            len_acc_q    <= '0;
            tail_data_q  <= {TAIL_BYTES{PAD_BYTE}};
            tail_len_q   <= '0;
            pkt_len_q    <= '0;
            tail_valid_q <= 1'b0;
            keep_err_q   <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_full_q  <= skid_full_d;
            tready_q     <= tready_d;
            in_pkt_q     <= in_pkt_d;
            tail_acc_q   <= tail_acc_d;
            len_acc_q    <= len_acc_d;
            tail_data_q  <= tail_data_d;
            tail_len_q   <= tail_len_d;
            pkt_len_q    <= pkt_len_d;
            tail_valid_q <= tail_valid_d;
            keep_err_q   <= keep_err_d;
        end
    end

    assign s.s_axis_tready = tready_q;
    assign s.out_data      = main_q.data;
    assign s.out_empty     = main_q.empty;
    assign s.out_sop       = main_q.sop;
    assign s.out_eop       = main_q.eop;
    assign s.out_valid     = main_valid_q;
    assign tail_data       = tail_data_q;
    assign tail_len        = tail_len_q;
    assign pkt_len         = pkt_len_q;
    assign tail_valid      = tail_valid_q;
    assign keep_err        = keep_err_q;
endmodule

// File: tb/tb_sme_stream_adapter.sv
// Bench for sme_stream_adapter: directed packets plus random traffic under
// random backpressure, checked against a packet-level byte model.
module tb_sme_stream_adapter;
    localparam int BC = 16;
    localparam int TN = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sme_stream_adapter_if #(.BYTE_COUNT(BC)) bus ();
    logic [TN*8-1:0] tail_data;
    logic [2:0]      tail_len;
    logic [15:0]     pkt_len;
    logic            tail_valid;
    logic            keep_err;

    sme_stream_adapter #(
        .BYTE_COUNT(BC), .TAIL_BYTES(TN), .PAD_BYTE(8'hFF), .LEN_W(16)
    ) dut (
        .clk(clk), .rst(rst), .s(bus),
        .tail_data(tail_data), .tail_len(tail_len), .pkt_len(pkt_len),
        .tail_valid(tail_valid), .keep_err(keep_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_mode = 0;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   empty;
        logic         sop;
        logic         eop;
    } obeat_t;

    typedef struct {
        logic [TN*8-1:0] data;
        int              tl;
        int              len;
        int              at;
    } texp_t;

    obeat_t      exp_beats[$];
    texp_t       tail_exp[$];
    int          err_exp[$];
    logic [7:0]  pkt_bytes[$];
    bit          m_in_pkt = 1'b0;

    // Reference: what the wire carried, as bytes, and what each beat must look like.
    function automatic void model_accept(input logic [127:0] d, input logic [15:0] k,
                                         input logic l, input int at);
        obeat_t b;
        texp_t  t;
        int     n;
        int     contig;
        n = $countones(k);
        for (int j = 0; j < BC; j++)
            b.data[(BC-1-j)*8 +: 8] = k[j] ? d[j*8 +: 8] : 8'hFF;
        b.sop   = !m_in_pkt;
        b.eop   = l;
        b.empty = !l ? 4'd0 : (k == 16'h0) ? 4'd15 : 4'((BC - n) % BC);
        exp_beats.push_back(b);
        if (!m_in_pkt) pkt_bytes.delete();
        for (int j = 0; j < n; j++) pkt_bytes.push_back(d[j*8 +: 8]);
        contig = (1 << n) - 1;
        if (int'(k) != contig || k == 16'h0 || (!l && k != 16'hFFFF)) err_exp.push_back(at);
        if (l) begin
            t.len = pkt_bytes.size();
            t.tl  = (t.len < TN) ? t.len : TN;
            for (int i = 0; i < TN; i++)
                t.data[i*8 +: 8] = (i < t.len) ? pkt_bytes[t.len-1-i] : 8'hFF;
            t.at = at;
            tail_exp.push_back(t);
        end
        m_in_pkt = !l;
    endfunction

    // Monitor: output beats, stall stability, tail and keep_err pulses.
    bit     prev_stall = 1'b0;
    obeat_t held;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", bus.out_valid, 1'b1);
                check_eq("hold_fields", {bus.out_data, bus.out_empty, bus.out_sop, bus.out_eop}, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_beats.size() == 0) begin
                    check_eq("spurious_beat", bus.out_valid, 1'b0);
                end else begin
                    obeat_t e;
                    e = exp_beats.pop_front();
                    check_eq("out_data", bus.out_data, e.data);
                    check_eq("out_sop", bus.out_sop, e.sop);
                    check_eq("out_eop", bus.out_eop, e.eop);
                    check_eq("out_empty", bus.out_empty, e.empty);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held = {bus.out_data, bus.out_empty, bus.out_sop, bus.out_eop};
            if (tail_valid) begin
                if (tail_exp.size() == 0) begin
                    check_eq("spurious_tail", tail_valid, 1'b0);
                end else begin
                    texp_t t;
                    t = tail_exp.pop_front();
                    check_eq("tail_data", tail_data, t.data);
                    check_eq("tail_len", tail_len, t.tl);
                    check_eq("pkt_len", pkt_len, t.len);
                    check_eq("tail_cycle", cyc, t.at);
                end
            end
            if (keep_err) begin
                if (err_exp.size() == 0) check_eq("spurious_keep_err", keep_err, 1'b0);
                else check_eq("keep_err_cycle", cyc, err_exp.pop_front());
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
        bit ok;
        ok = 1'b0;
        bus.s_axis_tdata  = d;
        bus.s_axis_tkeep  = k;
        bus.s_axis_tlast  = l;
        bus.s_axis_tvalid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.s_axis_tready) begin
                model_accept(d, k, l, cyc + 1);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check_eq("accept", ok, 1'b1);
    endtask

    task automatic idle();
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int t = 0; t < 300 && (exp_beats.size() != 0 || tail_exp.size() != 0 || err_exp.size() != 0); t++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check_eq("drained", exp_beats.size() + tail_exp.size() + err_exp.size(), 0);
    endtask

    function automatic logic [127:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] d;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_tready", bus.s_axis_tready, 1'b0);
        check_eq("rst_sop_eop_empty", {bus.out_sop, bus.out_eop, bus.out_empty}, 6'd0);
        check_eq("rst_out_data", bus.out_data, 128'd0);
        check_eq("rst_tail_data", tail_data, {TN{8'hFF}});
        check_eq("rst_tail_len_pkt_len", {tail_len, pkt_len}, 19'd0);
        check_eq("rst_pulses", {tail_valid, keep_err}, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("tready_after_rst", bus.s_axis_tready, 1'b1);
        @(posedge clk);
        #1;

        // Single 8-byte beat
        d = rnd_data();
        for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'(j);
        send(d, 16'h00FF, 1'b1);
        drain();
        check_eq("tp1_tail_data", tail_data, 56'h01020304050607);
        check_eq("tp1_tail_len", tail_len, 3'd7);
        check_eq("tp1_pkt_len", pkt_len, 16'd8);

        // 3-byte packet
        d = rnd_data();
        d[23:0] = 24'hCCBBAA;
        send(d, 16'h0007, 1'b1);
        drain();
        check_eq("tp2_tail_data", tail_data, 56'hFFFFFFFFAABBCC);
        check_eq("tp2_tail_len", tail_len, 3'd3);
        check_eq("tp2_pkt_len", pkt_len, 16'd3);

        // 2-beat packet of 18 bytes
        for (int j = 0; j < 16; j++) d[j*8 +: 8] = 8'(j);
        send(d, 16'hFFFF, 1'b0);
        d = rnd_data();
        d[15:0] = 16'h1110;
        send(d, 16'h0003, 1'b1);
        drain();
        check_eq("tp3_tail_data", tail_data, 56'h0B0C0D0E0F1011);
        check_eq("tp3_pkt_len", pkt_len, 16'd18);

        // Malformed keeps, including a zero-keep eop
        send(rnd_data(), 16'h00F0, 1'b1);
        send(rnd_data(), 16'h7FFF, 1'b0);
        send(rnd_data(), 16'h0001, 1'b1);
        send(rnd_data(), 16'hFFFF, 1'b0);
        send(rnd_data(), 16'h0000, 1'b1);
        drain();

        // Reset after beat 1 of 3, then a fresh 20-byte packet
        send(rnd_data(), 16'hFFFF, 1'b0);
        drain();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_in_pkt = 1'b0;
        pkt_bytes.delete();
        exp_beats.delete();
        @(negedge clk);
        check_eq("midrst_pkt_len", pkt_len, 16'd0);
        @(posedge clk);
        #1;
        send(rnd_data(), 16'hFFFF, 1'b0);
        send(rnd_data(), 16'h000F, 1'b1);
        drain();
        check_eq("midrst_new_pkt_len", pkt_len, 16'd20);

        // Random traffic under 50% backpressure
        rdy_mode = 1;
        for (int p = 0; p < 200; p++) begin
            int rem;
            rem = $urandom_range(1, 60);
            while (rem > 0) begin
                if (rem > BC) begin
                    send(rnd_data(), 16'hFFFF, 1'b0);
                    rem -= BC;
                end else begin
                    send(rnd_data(), 16'((1 << rem) - 1), 1'b1);
                    rem = 0;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
